// File: rtl/jam_pkg.sv
// Shared JAM definitions: matrix geometry, cost type and cost-table FSM states.
package jam_pkg;

  localparam int unsigned N_DIM         = 8;
  localparam int unsigned COST_W        = 7;
  localparam int unsigned IDX_W         = 3;
  localparam int unsigned ADDR_W        = 2 * IDX_W;
  localparam int unsigned N_ENTRY       = N_DIM * N_DIM;
  localparam int unsigned MIN_COST_INIT = 1023;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_READY = 2'd2
  } state_t;

  typedef logic [COST_W-1:0] cost_t;

endpackage

// File: rtl/jam_cost_regfile.sv
// 64-entry cost register file: one synchronous write port, one combinational (w,j) read port.
module jam_cost_regfile
  import jam_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  cost_t             wdata,
  input  logic [IDX_W-1:0]  rw,
  input  logic [IDX_W-1:0]  rj,
  output cost_t             rdata_c
);

  cost_t mem_q [N_ENTRY];
  cost_t mem_d [N_ENTRY];

  // Contents are deliberately not reset; readers gate on table-ready.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata_c = mem_q[{rw, rj}];

endmodule

// File: rtl/jam_cost_table.sv
// JAM cost store: streams in an 8x8 cost matrix, then serves zero-latency (W,J) lookups.
// Optional checksum beat and sticky LOAD_ERR enabled by defining COST_CHKSUM_EN.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  cost_t            IN_DATA,
  input  logic             RELOAD,
  output logic             TABLE_READY,
  input  logic [IDX_W-1:0] W,
  input  logic [IDX_W-1:0] J,
  output cost_t            Cost,
  output logic             LOAD_ERR
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              table_ready_q, table_ready_d;
  logic              load_err_q, load_err_d;
  logic              we_c;
  logic              accept_c;
  cost_t             rdata_c;
`ifdef COST_CHKSUM_EN
  cost_t             chk_q, chk_d;
`endif

  assign accept_c = IN_VALID & in_ready_q;

  // Next-state, load counter and checksum; RELOAD overrides any beat in the same cycle.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    load_err_d = load_err_q;
    we_c       = 1'b0;
`ifdef COST_CHKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept_c) begin
          we_c       = 1'b1;
          load_cnt_d = load_cnt_q + ADDR_W'(1);
`ifdef COST_CHKSUM_EN
          chk_d      = chk_q + IN_DATA;
`endif
          if (load_cnt_q == ADDR_W'(N_ENTRY - 1)) begin
`ifdef COST_CHKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_READY;
`endif
          end
        end
      end
`ifdef COST_CHKSUM_EN
      ST_CHECK: begin
        if (accept_c) begin
          if (IN_DATA != chk_q) begin
            load_err_d = 1'b1;
          end
          state_d = ST_READY;
        end
      end
`endif
      default: begin
      end
    endcase
    if (RELOAD) begin
      state_d    = ST_LOAD;
      load_cnt_d = '0;
      load_err_d = 1'b0;
      we_c       = 1'b0;
`ifdef COST_CHKSUM_EN
      chk_d      = '0;
`endif
    end
    in_ready_d    = (state_d != ST_READY);
    table_ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_LOAD;
      load_cnt_q    <= '0;
      in_ready_q    <= 1'b1;
      table_ready_q <= 1'b0;
      load_err_q    <= 1'b0;
`ifdef COST_CHKSUM_EN
      chk_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      in_ready_q    <= in_ready_d;
      table_ready_q <= table_ready_d;
      load_err_q    <= load_err_d;
`ifdef COST_CHKSUM_EN
      chk_q         <= chk_d;
`endif
    end
  end

  jam_cost_regfile u_regfile (
    .clk     (CLK),
    .we      (we_c),
    .waddr   (load_cnt_q),
    .wdata   (IN_DATA),
    .rw      (W),
    .rj      (J),
    .rdata_c (rdata_c)
  );

  assign IN_READY    = in_ready_q;
  assign TABLE_READY = table_ready_q;
  assign LOAD_ERR    = load_err_q;
  assign Cost        = table_ready_q ? rdata_c : '0;

endmodule
